// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32/RV64 integer ALU with an optional iterative multiply/divide unit.
// The multiply/divide unit is present only when ALU_MULDIV_M_EXT_EN is defined; otherwise M encodings return illegal.
module alu_muldiv #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            op_imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] immediate,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  // Reject unsupported configurations at elaboration time.
  if (!((XLEN == 32) || (XLEN == 64)) ||
      !((MUL_BITS_PER_CYCLE == 1) || (MUL_BITS_PER_CYCLE == 2) || (MUL_BITS_PER_CYCLE == 4))) begin : g_bad_param
    $error("alu_muldiv: unsupported XLEN or MUL_BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DONE
`ifdef ALU_MULDIV_M_EXT_EN
    ,
    S_MUL,
    S_DIV
`endif
  } state_t;

  state_t state;

  logic            accept;
  logic [XLEN-1:0] op2;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_ill;
  logic            m_req;

  // Single-cycle base ALU and request decode.
  always_comb begin
    accept   = in_valid && in_ready;
    op2      = op_imm ? immediate : rs2;
    shamt    = op2[SHW-1:0];
    base_ill = op_imm && (funct3[1:0] == 2'b01) && ((funct7 & 7'b1011111) != 7'd0);
    m_req    = !op_imm && (funct7 == 7'b0000001);
    base_res = '0;
    case (funct3)
      3'b000:  base_res = (!op_imm && funct7[5]) ? (rs1 - op2) : (rs1 + op2);
      3'b001:  base_res = rs1 << shamt;
      3'b010:  base_res = XLEN'($signed(rs1) < $signed(op2));
      3'b011:  base_res = XLEN'(rs1 < op2);
      3'b100:  base_res = rs1 ^ op2;
      3'b101:  base_res = funct7[5] ? XLEN'($signed(rs1) >>> shamt) : (rs1 >> shamt);
      3'b110:  base_res = rs1 | op2;
      3'b111:  base_res = rs1 & op2;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_M_EXT_EN
  localparam int unsigned CNTW      = $clog2(XLEN + 1);
  localparam int unsigned MUL_ITERS = XLEN / MUL_BITS_PER_CYCLE;
  localparam logic [CNTW-1:0] MUL_LAST = CNTW'(MUL_ITERS - 1);
  localparam logic [CNTW-1:0] DIV_LAST = CNTW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  logic [CNTW-1:0]   cnt;
  logic [2*XLEN-1:0] mul_acc, mul_mcand, mul_acc_nxt;
  logic [XLEN-1:0]   mul_mplier, mul_corr, mul_corr_init, mul_hi, mul_res;
  logic              mul_lo, a_sgn, b_sgn;
  logic [XLEN-1:0]   div_rem, div_quo, div_den, div_rem_nxt, div_quo_nxt, div_res;
  logic [XLEN-1:0]   a_mag, b_mag, div_byp_res;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_qneg, div_rneg, div_rem_sel, div_sgn, div_bypass;

  // Multiply: unsigned shift-add on raw bit patterns; signed operands are fixed up in the high half.
  always_comb begin
    a_sgn         = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
    b_sgn         = (funct3[1:0] == 2'b01);
    mul_corr_init = ((a_sgn && rs1[XLEN-1]) ? rs2 : '0) + ((b_sgn && rs2[XLEN-1]) ? rs1 : '0);
    mul_acc_nxt   = mul_acc;
    for (int unsigned j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (mul_mplier[j]) mul_acc_nxt = mul_acc_nxt + (mul_mcand << j);
    end
    mul_hi  = mul_acc_nxt[2*XLEN-1:XLEN] - mul_corr;
    mul_res = mul_lo ? mul_acc_nxt[XLEN-1:0] : mul_hi;
  end

  // Divide: restoring division on magnitudes, signs applied to the final iteration's outputs.
  always_comb begin
    div_sgn     = !funct3[0];
    a_mag       = (div_sgn && rs1[XLEN-1]) ? (-rs1) : rs1;
    b_mag       = (div_sgn && rs2[XLEN-1]) ? (-rs2) : rs2;
    div_bypass  = (rs2 == '0) || (div_sgn && (rs1 == XMIN) && (rs2 == '1));
    div_byp_res = (rs2 == '0) ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);
    div_trial   = {div_rem, div_quo[XLEN-1]};
    div_diff    = div_trial - {1'b0, div_den};
    if (!div_diff[XLEN]) begin
      div_rem_nxt = div_diff[XLEN-1:0];
      div_quo_nxt = {div_quo[XLEN-2:0], 1'b1};
    end else begin
      div_rem_nxt = div_trial[XLEN-1:0];
      div_quo_nxt = {div_quo[XLEN-2:0], 1'b0};
    end
    if (div_rem_sel) div_res = div_rneg ? (-div_rem_nxt) : div_rem_nxt;
    else             div_res = div_qneg ? (-div_quo_nxt) : div_quo_nxt;
  end

  // Iterative datapath registers; loaded on accept, advanced only in their own state.
  always_ff @(posedge clock) begin
    if (accept) begin
      mul_acc     <= '0;
      mul_mcand   <= {XLEN'(0), rs1};
      mul_mplier  <= rs2;
      mul_corr    <= mul_corr_init;
      mul_lo      <= (funct3[1:0] == 2'b00);
      div_rem     <= '0;
      div_quo     <= a_mag;
      div_den     <= b_mag;
      div_qneg    <= div_sgn && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      div_rneg    <= div_sgn && rs1[XLEN-1];
      div_rem_sel <= funct3[1];
    end else if (state == S_MUL) begin
      mul_acc    <= mul_acc_nxt;
      mul_mcand  <= mul_mcand << MUL_BITS_PER_CYCLE;
      mul_mplier <= mul_mplier >> MUL_BITS_PER_CYCLE;
    end else if (state == S_DIV) begin
      div_rem <= div_rem_nxt;
      div_quo <= div_quo_nxt;
    end
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
`ifdef ALU_MULDIV_M_EXT_EN
      cnt       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (!m_req) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= base_ill ? '0 : base_res;
              illegal   <= base_ill;
            end
`ifdef ALU_MULDIV_M_EXT_EN
            else if (!funct3[2]) begin
              state <= S_MUL;
              cnt   <= '0;
            end else if (div_bypass) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= div_byp_res;
              illegal   <= 1'b0;
            end else begin
              state <= S_DIV;
              cnt   <= '0;
            end
`else
            else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= '0;
              illegal   <= 1'b1;
            end
`endif
          end
        end
`ifdef ALU_MULDIV_M_EXT_EN
        S_MUL: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == MUL_LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= mul_res;
            illegal   <= 1'b0;
          end
        end
        S_DIV: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == DIV_LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= div_res;
            illegal   <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (XLEN=32); covers both ALU_MULDIV_M_EXT_EN builds.
module tb_alu_muldiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        op_imm = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0, immediate = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        illegal;

  alu_muldiv #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .op_imm(op_imm),
    .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .out_valid(out_valid), .result(result), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_ov = 1'b0;

  localparam int LONG = 33;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per out_valid pulse.
  initial begin
    forever begin
      @(negedge clock);
      if (prev_ov) chk("out_valid_pulse_width", {31'd0, out_valid}, 32'd0);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got result %h illegal %b expected no response", result, illegal);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
          chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input string name, input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] er, input logic ei, input int lat,
                       input bit hold, input bit track);
    int waited;
    waited = 0;
    @(negedge clock);
    op_imm = imm; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; immediate = im;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got in_ready %b expected 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    if (track) sbq.push_back('{name, er, ei, lat, cyc});
    @(posedge clock);
    @(negedge clock);
    if (hold) begin
      chk({name, "_ready_in_done"}, {31'd0, in_ready}, 32'd0);
      rs1 = a ^ 32'h5A5A_0001;
      rs2 = b ^ 32'h0000_0003;
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_illegal"}, {31'd0, illegal}, 32'd0);
    chk({name, "_result"}, result, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_result", result, 32'd0);

    //      name        imm   f3      f7           rs1           rs2           imm           exp           ill lat h t
    issue("sub",        1'b0, 3'b000, 7'b0100000, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 0, 1, 0, 1);
    issue("srai",       1'b1, 3'b101, 7'b0100000, 32'h80000000, 32'd0,        32'd4,        32'hF8000000, 0, 1, 0, 1);
    issue("add",        1'b0, 3'b000, 7'b0000000, 32'd1,        32'd1,        32'd0,        32'd2,        0, 1, 0, 1);
    issue("add_wrap",   1'b0, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 1, 0, 1);
    issue("addi_ovf",   1'b1, 3'b000, 7'b0000000, 32'h7FFFFFFF, 32'd0,        32'd1,        32'h80000000, 0, 1, 0, 1);
    issue("addi_f7",    1'b1, 3'b000, 7'b0100000, 32'd10,       32'd0,        32'd3,        32'd13,       0, 1, 0, 1);
    issue("sll_mask",   1'b0, 3'b001, 7'b0000000, 32'd1,        32'h25,       32'd0,        32'h20,       0, 1, 0, 1);
    issue("slt",        1'b0, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        0, 1, 0, 1);
    issue("sltu",       1'b0, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 1, 0, 1);
    issue("slti",       1'b1, 3'b010, 7'b0000000, 32'd5,        32'd0,        32'hFFFFFFFD, 32'd0,        0, 1, 0, 1);
    issue("sltiu",      1'b1, 3'b011, 7'b0000000, 32'd5,        32'd0,        32'hFFFFFFFD, 32'd1,        0, 1, 0, 1);
    issue("or",         1'b0, 3'b110, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000FFF0, 0, 1, 0, 1);
    issue("and",        1'b0, 3'b111, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000F000, 0, 1, 0, 1);
    issue("srl",        1'b0, 3'b101, 7'b0000000, 32'h80000000, 32'd31,       32'd0,        32'd1,        0, 1, 0, 1);
    issue("sra",        1'b0, 3'b101, 7'b0100000, 32'h80000000, 32'd31,       32'd0,        32'hFFFFFFFF, 0, 1, 0, 1);
    issue("xor",        1'b0, 3'b100, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h00000FF0, 0, 1, 0, 1);
    repeat (5) @(negedge clock);
    chk("result_hold", result, 32'h00000FF0);
    chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
    issue("slli_ill",   1'b1, 3'b001, 7'b0000010, 32'd1,        32'd0,        32'd1,        32'd0,        1, 1, 0, 1);
    issue("srai_ill",   1'b1, 3'b101, 7'b0100001, 32'hFFFFFFFF, 32'd0,        32'd1,        32'd0,        1, 1, 0, 1);
    issue("legal_after",1'b1, 3'b001, 7'b0000000, 32'd3,        32'd0,        32'd2,        32'd12,       0, 1, 0, 1);

`ifdef ALU_MULDIV_M_EXT_EN
    issue("mulh",       1'b0, 3'b001, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        0, LONG, 0, 1);
    issue("mulhu",      1'b0, 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 0, LONG, 0, 1);
    issue("mul",        1'b0, 3'b000, 7'b0000001, 32'd3,        32'd4,        32'd0,        32'd12,       0, LONG, 0, 1);
    issue("mulhsu",     1'b0, 3'b010, 7'b0000001, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 0, LONG, 0, 1);
    issue("div_ovf",    1'b0, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0, 1, 0, 1);
    issue("divu_zero",  1'b0, 3'b101, 7'b0000001, 32'd100,      32'd0,        32'd0,        32'hFFFFFFFF, 0, 1, 0, 1);
    issue("rem_zero",   1'b0, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd0,        32'd0,        32'hFFFFFFF9, 0, 1, 0, 1);
    issue("rem_neg",    1'b0, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2,        32'd0,        32'hFFFFFFFF, 0, LONG, 0, 1);
    issue("div_neg",    1'b0, 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'd2,        32'd0,        32'hFFFFFFFD, 0, LONG, 0, 1);
    issue("remu",       1'b0, 3'b111, 7'b0000001, 32'd100,      32'd7,        32'd0,        32'd2,        0, LONG, 0, 1);
    issue("add_hold",   1'b0, 3'b000, 7'b0000000, 32'd20,       32'd22,       32'd0,        32'd42,       0, 1, 1, 1);
    issue("divu_abort", 1'b0, 3'b101, 7'b0000001, 32'd1000,     32'd7,        32'd0,        32'd0,        0, 0, 0, 0);
    repeat (8) @(negedge clock);
    pulse_reset("abort_reset");
    issue("add_post",   1'b0, 3'b000, 7'b0000000, 32'd1,        32'd1,        32'd0,        32'd2,        0, 1, 0, 1);
`else
    issue("mul_hold",   1'b0, 3'b000, 7'b0000001, 32'd3,        32'd4,        32'd0,        32'd0,        1, 1, 1, 1);
    issue("div_noext",  1'b0, 3'b100, 7'b0000001, 32'd100,      32'd7,        32'd0,        32'd0,        1, 1, 0, 1);
    issue("add_post",   1'b0, 3'b000, 7'b0000000, 32'd1,        32'd1,        32'd0,        32'd2,        0, 1, 0, 1);
    repeat (3) @(negedge clock);
    pulse_reset("mid_reset");
`endif

    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
